multi_operand_proc: RTL and testbench

//  Parametrised sequential processing unit behind the switch-driven top level. Holds NUM_OPS

---
 rtl/multi_operand_proc.sv | 119 +++++++++++
 tb/tb_multi_operand_proc.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multi_operand_proc.sv
// Sequential fold unit: NUM_OPS operand registers reduced in index order, one per cycle,
// with sum/max/min/xor selected by a mode latched at start.
module multi_operand_proc #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_OPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   ld_data,
  input  logic [NUM_OPS-1:0] ld_sel,
  input  logic [1:0]         mode,
  input  logic               start,
  output logic [WIDTH-1:0]   result,
  output logic               ovf,
  output logic               rdy,
  output logic               proc,
  output logic               done
);

  localparam int unsigned IdxW = $clog2(NUM_OPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] ops_q [NUM_OPS];
  logic [WIDTH-1:0] ops_d [NUM_OPS];

  logic [WIDTH-1:0] op;
  logic [WIDTH:0]   sum_w;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ops_d    = ops_q;
    op       = ops_q[idx_q];
    sum_w    = {1'b0, acc_q} + {1'b0, op};

    unique case (state_q)
      StIdle: begin
        for (int i = 0; i < NUM_OPS; i++) begin
          if (ld_sel[i]) ops_d[i] = ld_data;
        end
        if (start) begin
          mode_d  = mode;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (idx_q == '0) begin
          acc_d   = op;
          carry_d = 1'b0;
        end else begin
          unique case (mode_q)
            2'b00: begin
              acc_d   = sum_w[WIDTH-1:0];
              carry_d = carry_q | sum_w[WIDTH];
            end
            2'b01:   acc_d = (op > acc_q) ? op : acc_q;
            2'b10:   acc_d = (op < acc_q) ? op : acc_q;
            default: acc_d = acc_q ^ op;
          endcase
        end
        // Last operand: publish the freshly folded value in the same edge.
        if (idx_q == LastIdx) begin
          result_d = acc_d;
          ovf_d    = carry_d & (mode_q == 2'b00);
          state_d  = StDone;
        end else begin
          idx_d = idx_q + IdxOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 2'b00;
      result_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_d[i];
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign rdy    = (state_q == StIdle);
  assign proc   = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_multi_operand_proc.sv
// Directed bench for multi_operand_proc with hand-computed expectations.
module tb_multi_operand_proc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ld_data;
  logic [3:0] ld_sel;
  logic [1:0] mode;
  logic       start;
  logic [3:0] result;
  logic       ovf, rdy, proc, done;

  int n_checks = 0;
  int n_fail   = 0;

  multi_operand_proc #(.WIDTH(4), .NUM_OPS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_data(ld_data),
    .ld_sel (ld_sel),
    .mode   (mode),
    .start  (start),
    .result (result),
    .ovf    (ovf),
    .rdy    (rdy),
    .proc   (proc),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] sel, input logic [3:0] data);
    ld_sel  = sel;
    ld_data = data;
    @(negedge clk);
    ld_sel  = '0;
    ld_data = '0;
  endtask

  // Start an operation and follow it cycle by cycle; meddle injects loads/mode/start in RUN.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [3:0] exp_res,
                        input logic exp_ovf, input bit meddle);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check({tag, " proc"}, proc, 1'b1);
      check({tag, " done_in_run"}, done, 1'b0);
      if (meddle && c == 1) begin
        ld_sel  = 4'hF;
        ld_data = 4'hF;
        mode    = ~m;
        start   = 1'b1;
      end else if (meddle && c == 2) begin
        ld_sel  = '0;
        ld_data = '0;
        mode    = m;
        start   = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " proc_off"}, proc, 1'b0);
    check({tag, " result"}, result, exp_res);
    check({tag, " ovf"}, ovf, exp_ovf);
    @(negedge clk);
    check({tag, " rdy"}, rdy, 1'b1);
    check({tag, " done_off"}, done, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ld_data = '0;
    ld_sel  = '0;
    mode    = 2'b00;
    start   = 1'b0;

    // 1: reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst result", result, 4'h0);
    check("rst ovf", ovf, 1'b0);
    check("rst rdy", rdy, 1'b1);
    check("rst proc", proc, 1'b0);
    check("rst done", done, 1'b0);
    run_op("rst ops_zero", 2'b00, 4'h0, 1'b0, 1'b0);

    // 2: sum 3+5+7+9 = 24 -> 8 with carry
    load(4'b0001, 4'd3);
    load(4'b0010, 4'd5);
    load(4'b0100, 4'd7);
    load(4'b1000, 4'd9);
    run_op("sum", 2'b00, 4'd8, 1'b1, 1'b0);

    // 3: max, min, xor
    run_op("max", 2'b01, 4'd9, 1'b0, 1'b0);
    run_op("min", 2'b10, 4'd3, 1'b0, 1'b0);
    run_op("xor", 2'b11, 4'd8, 1'b0, 1'b0);

    // 4: inputs ignored during RUN, operands frozen
    load(4'b1111, 4'd1);
    run_op("frozen", 2'b00, 4'd4, 1'b0, 1'b1);
    run_op("frozen_ops", 2'b00, 4'd4, 1'b0, 1'b0);

    // 5: reset mid-RUN
    mode  = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort proc1", proc, 1'b1);
    @(negedge clk);
    check("abort proc2", proc, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort rdy", rdy, 1'b1);
    check("abort result", result, 4'h0);
    check("abort done", done, 1'b0);
    check("abort proc", proc, 1'b0);
    @(negedge clk);
    check("abort no_done", done, 1'b0);

    // 6: load on the same edge as start
    ld_sel  = 4'b0001;
    ld_data = 4'hA;
    run_op("same_edge_load", 2'b01, 4'hA, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (observed running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule
